// File: rtl/mem_loader_if.sv
// Bus bundle between the UART-fed memory loader, the CPU store port and data memory.
// The loader itself takes the slave view; whoever drives it takes the master view.
interface mem_loader_if;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        cpu_mem_write;
  logic [31:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        loading;
  logic        load_done;
  logic [14:0] word_count;

  modport master (
    output load_start, rx_valid, rx_byte,
    output cpu_mem_write, cpu_address, cpu_write_data,
    input  mem_write, mem_address, mem_write_data,
    input  loading, load_done, word_count
  );

  modport slave (
    input  load_start, rx_valid, rx_byte,
    input  cpu_mem_write, cpu_address, cpu_write_data,
    output mem_write, mem_address, mem_write_data,
    output loading, load_done, word_count
  );
endinterface

// File: rtl/mem_loader.sv
// Packs UART bytes little-endian into 32-bit words and writes them to data memory,
// holding the CPU off the memory port while a load is in progress.
module mem_loader #(
  parameter int MAX_WORDS = 16384,
  parameter int TIMEOUT   = 1000000
) (
  input  logic        clock,
  input  logic        rst_n,
  mem_loader_if.slave bus
);

  localparam int TIMER_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT - 1);
  localparam logic [13:0] LAST_PTR = 14'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FLUSH,
    DONE
  } state_t;

  state_t                 state, state_next;
  logic [13:0]            word_ptr, word_ptr_next;
  logic [1:0]             byte_idx, byte_idx_next;
  logic [31:0]            assembly, assembly_next;
  logic [TIMER_WIDTH-1:0] timer, timer_next;
  logic [14:0]            word_count, word_count_next;
  logic                   load_done, load_done_next;

  logic                   mem_write;
  logic [31:0]            mem_address;
  logic [31:0]            mem_write_data;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_ptr   <= '0;
      byte_idx   <= '0;
      assembly   <= '0;
      timer      <= '0;
      word_count <= '0;
      load_done  <= 1'b0;
    end else begin
      state      <= state_next;
      word_ptr   <= word_ptr_next;
      byte_idx   <= byte_idx_next;
      assembly   <= assembly_next;
      timer      <= timer_next;
      word_count <= word_count_next;
      load_done  <= load_done_next;
    end
  end

  always_comb begin
    state_next      = state;
    word_ptr_next   = word_ptr;
    byte_idx_next   = byte_idx;
    assembly_next   = assembly;
    timer_next      = timer;
    word_count_next = word_count;
    load_done_next  = load_done;
    mem_write       = 1'b0;
    mem_address     = {16'b0, word_ptr, 2'b00};
    mem_write_data  = assembly;

    case (state)
      IDLE: begin
        mem_write      = bus.cpu_mem_write;
        mem_address    = bus.cpu_address;
        mem_write_data = bus.cpu_write_data;
        if (bus.load_start) begin
          state_next      = COLLECT;
          word_ptr_next   = '0;
          byte_idx_next   = '0;
          assembly_next   = '0;
          timer_next      = '0;
          word_count_next = '0;
          load_done_next  = 1'b0;
        end
      end

      COLLECT: begin
        if (bus.rx_valid) begin
          assembly_next[{byte_idx, 3'b000} +: 8] = bus.rx_byte;
          byte_idx_next = byte_idx + 2'd1;
          timer_next    = '0;
          if (byte_idx == 2'd3) begin
            state_next = WRITE;
          end
        end else if (timer == TIMER_LAST) begin
          state_next = (byte_idx != 2'd0) ? FLUSH : DONE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      // A byte arriving alongside the write starts the next word instead of being dropped.
      WRITE: begin
        mem_write       = 1'b1;
        word_count_next = word_count + 1'b1;
        byte_idx_next   = '0;
        assembly_next   = '0;
        timer_next      = '0;
        if (word_ptr == LAST_PTR) begin
          state_next = DONE;
        end else begin
          state_next    = COLLECT;
          word_ptr_next = word_ptr + 1'b1;
          if (bus.rx_valid) begin
            assembly_next = {24'b0, bus.rx_byte};
            byte_idx_next = 2'd1;
          end
        end
      end

      FLUSH: begin
        mem_write       = 1'b1;
        word_count_next = word_count + 1'b1;
        state_next      = DONE;
      end

      DONE: begin
        load_done_next = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mem_write      = mem_write;
  assign bus.mem_address    = mem_address;
  assign bus.mem_write_data = mem_write_data;
  assign bus.loading        = (state != IDLE);
  assign bus.load_done      = load_done;
  assign bus.word_count     = word_count;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: expected memory writes go into a scoreboard queue
// that an independent monitor drains whenever the loader asserts mem_write.
module tb_mem_loader;

  localparam int MAX_WORDS = 4;
  localparam int TIMEOUT   = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } write_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  write_t expected_q[$];

  mem_loader_if bus();

  mem_loader #(
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic start, input logic valid, input logic [7:0] data);
    bus.load_start = start;
    bus.rx_valid   = valid;
    bus.rx_byte    = data;
    @(posedge clock);
    #1;
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] data);
    apply_stimulus(1'b0, 1'b1, data);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    write_t w;
    w.addr = addr;
    w.data = data;
    expected_q.push_back(w);
  endtask

  task automatic set_cpu(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_mem_write  = we;
    bus.cpu_address    = addr;
    bus.cpu_write_data = data;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.loading && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output(name, 32'(bus.loading), 32'd0);
  endtask

  // Monitor: every memory write the loader issues must match the next queued expectation.
  always @(negedge clock) begin
    write_t w;
    if (bus.mem_write) begin
      if (expected_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL sb_unexpected: got write 0x%08h at 0x%08h, expected no write",
                 bus.mem_write_data, bus.mem_address);
      end else begin
        w = expected_q.pop_front();
        check_output("sb_address", bus.mem_address, w.addr);
        check_output("sb_data", bus.mem_write_data, w.data);
      end
    end
  end

  initial begin
    int n;
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    bus.rx_byte    = 8'h00;
    set_cpu(1'b0, 32'h0, 32'h0);

    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;
    check_output("reset_loading", 32'(bus.loading), 32'd0);
    check_output("reset_load_done", 32'(bus.load_done), 32'd0);
    check_output("reset_word_count", 32'(bus.word_count), 32'd0);

    // CPU passthrough while idle
    expect_write(32'h0000_0010, 32'hCAFE_BABE);
    set_cpu(1'b1, 32'h0000_0010, 32'hCAFE_BABE);
    #1;
    check_output("pass_mem_write", 32'(bus.mem_write), 32'd1);
    check_output("pass_address", bus.mem_address, 32'h0000_0010);
    check_output("pass_data", bus.mem_write_data, 32'hCAFE_BABE);
    check_output("pass_loading", 32'(bus.loading), 32'd0);
    @(posedge clock);
    #1;
    set_cpu(1'b0, 32'h0, 32'h0);

    // Single word, with a CPU store held active that must be ignored
    expect_write(32'h0, 32'h1234_5678);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("single_loading", 32'(bus.loading), 32'd1);
    set_cpu(1'b1, 32'h0000_0100, 32'hFFFF_FFFF);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    check_output("single_cpu_blocked", 32'(bus.mem_write), 32'd0);
    send_byte(8'h12);
    check_output("single_latency", 32'(bus.mem_write), 32'd1);
    set_cpu(1'b0, 32'h0, 32'h0);
    wait_idle("single_idle");
    check_output("single_load_done", 32'(bus.load_done), 32'd1);
    check_output("single_word_count", 32'(bus.word_count), 32'd1);

    // Back-to-back bytes, fifth byte lands in the WRITE cycle, stray load_start ignored
    expect_write(32'h0, 32'h0403_0201);
    expect_write(32'h4, 32'h0807_0605);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("b2b_load_done_cleared", 32'(bus.load_done), 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    apply_stimulus(1'b1, 1'b1, 8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    send_byte(8'h08);
    wait_idle("b2b_idle");
    check_output("b2b_word_count", 32'(bus.word_count), 32'd2);

    // Partial word flushed after the idle timeout
    expect_write(32'h0, 32'h0000_BBAA);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    n = 0;
    while (!bus.mem_write && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_output("flush_delay", 32'(n), 32'd16);
    wait_idle("flush_idle");
    check_output("flush_word_count", 32'(bus.word_count), 32'd1);
    check_output("flush_load_done", 32'(bus.load_done), 32'd1);

    // Capacity limit: four words fill memory, later bytes are ignored
    expect_write(32'h0, 32'h0302_0100);
    expect_write(32'h4, 32'h0706_0504);
    expect_write(32'h8, 32'h0B0A_0908);
    expect_write(32'hC, 32'h0F0E_0D0C);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i));
    end
    check_output("cap_last_address", bus.mem_address, 32'h0000_000C);
    send_byte(8'hEE);
    send_byte(8'hEE);
    send_byte(8'hEE);
    check_output("cap_loading", 32'(bus.loading), 32'd0);
    check_output("cap_load_done", 32'(bus.load_done), 32'd1);
    check_output("cap_word_count", 32'(bus.word_count), 32'd4);

    // Reset in the middle of a word aborts the load
    apply_stimulus(1'b1, 1'b0, 8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    check_output("abort_loading", 32'(bus.loading), 32'd0);
    check_output("abort_load_done", 32'(bus.load_done), 32'd0);
    check_output("abort_word_count", 32'(bus.word_count), 32'd0);
    expect_write(32'h0000_0020, 32'h55AA_55AA);
    set_cpu(1'b1, 32'h0000_0020, 32'h55AA_55AA);
    #1;
    check_output("abort_cpu_write", 32'(bus.mem_write), 32'd1);
    @(posedge clock);
    #1;
    set_cpu(1'b0, 32'h0, 32'h0);
    repeat (20) @(posedge clock);
    #1;

    check_output("scoreboard_drained", 32'(expected_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
